// File: rtl/memory_responder.sv
// Single-port word memory behind a valid/ready request and a one-cycle response strobe.
// Supports RV32I byte/half/word loads and stores with alignment, range and funct3 checks.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t state_q, state_d;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic [31:0] rdata_q;
  logic        error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          out_of_range;
  logic          misaligned;
  logic          bad_funct3;
  logic          access_err;
  logic          mem_we;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_word;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
    end
  end

  // Word index comparison avoids forming 4*DEPTH_WORDS, which could overflow 32 bits.
  always_comb begin
    out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    misaligned   = 1'b0;
    case (funct3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (write_q) begin
      bad_funct3 = !(funct3_q == 3'b000 || funct3_q == 3'b001 || funct3_q == 3'b010);
    end else begin
      bad_funct3 = (funct3_q == 3'b011 || funct3_q == 3'b110 || funct3_q == 3'b111);
    end
    access_err = out_of_range || misaligned || bad_funct3;
  end

  always_comb begin
    byte_en = 4'b0000;
    wr_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = wdata_q;
      end
    endcase
  end

  assign word_idx = addr_q[AW+1:2];
  assign mem_we   = (state_q == ACCESS) && !reset && write_q && !access_err;

  // No reset on storage: contents survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  assign mem_word = mem[word_idx];

  always_comb begin
    load_byte = mem_word[8*addr_q[1:0] +: 8];
    load_half = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = mem_word;
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      rdata_q <= (write_q || access_err) ? '0 : load_data;
      error_q <= access_err;
    end else begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end
  end

  assign rsp_valid = (state_q == RESPOND);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a driver queues expected responses,
// an independent monitor compares them whenever rsp_valid is seen.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  memory_responder #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response strobe, checks data, error and latency.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.name, "_error"}, {31'd0, rsp_error}, {31'd0, e.err});
          chk({e.name, "_latency"}, cyc, e.cyc);
        end
      end else if (rsp_rdata !== 32'd0 || rsp_error !== 1'b0) begin
        chk("idle_outputs", {rsp_rdata[30:0], rsp_error}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic do_req(input string name, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic [31:0] er, input bit ee);
    int n;
    exp_t e;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + 2;
      e.name  = name;
      expq.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int accepts;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    do_req("sw_10",   1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    do_req("lw_10",   0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    do_req("lb_13",   0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 0);
    do_req("lbu_13",  0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 0);
    do_req("lh_10",   0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 0);
    do_req("lhu_12",  0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 0);
    do_req("lb_10",   0, 32'h10, 32'h0, 3'b000, 32'hFFFFFFEF, 0);
    do_req("sb_11",   1, 32'h11, 32'h00000055, 3'b000, 32'h0, 0);
    do_req("lw_sb",   0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 0);
    do_req("sh_12",   1, 32'h12, 32'h00001234, 3'b001, 32'h0, 0);
    do_req("lw_sh",   0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 0);
    do_req("lw_11",   0, 32'h11, 32'h0, 3'b010, 32'h0, 1);
    do_req("sh_13",   1, 32'h13, 32'hFFFFFFFF, 3'b001, 32'h0, 1);
    do_req("lw_after_err", 0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 0);
    do_req("lw_1000", 0, 32'h1000, 32'h0, 3'b010, 32'h0, 1);
    do_req("lw_huge", 0, 32'hFFFFFFFC, 32'h0, 3'b010, 32'h0, 1);
    do_req("ld_f011", 0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
    do_req("st_f100", 1, 32'h10, 32'h0, 3'b100, 32'h0, 1);
    do_req("sw_ffc",  1, 32'hFFC, 32'h80000001, 3'b010, 32'h0, 0);
    do_req("lh_ffe",  0, 32'hFFE, 32'h0, 3'b001, 32'hFFFF8000, 0);
    do_req("sw_24",   1, 32'h24, 32'h00000000, 3'b010, 32'h0, 0);

    // Held req_valid: accepts only when ready, i.e. every third cycle.
    wait_idle();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h0BADF00D;
    req_funct3 = 3'b010;
    accepts = 0;
    for (int k = 0; k < 9; k++) begin
      chk("hold_ready", {31'd0, req_ready}, {31'd0, (k % 3) == 0});
      if (req_ready === 1'b1) begin
        exp_t e;
        e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc + 2; e.name = "hold_sw";
        expq.push_back(e);
        accepts++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hold_accepts", accepts, 32'd3);

    // Request fields changing after accept must not leak into the access.
    wait_idle();
    do_req("sw_20_latch", 1, 32'h20, 32'h11111111, 3'b010, 32'h0, 0);
    req_valid = 1'b1;
    req_addr  = 32'h24;
    req_wdata = 32'h22222222;
    @(negedge clk);
    req_valid = 1'b0;
    do_req("lw_20", 0, 32'h20, 32'h0, 3'b010, 32'h11111111, 0);
    do_req("lw_24", 0, 32'h24, 32'h0, 3'b010, 32'h00000000, 0);

    // Reset during ACCESS aborts the store and its response.
    do_req("sw_30_zero", 1, 32'h30, 32'h00000000, 3'b010, 32'h0, 0);
    wait_idle();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h30;
    req_wdata  = 32'hA5A5A5A5;
    req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("abort_no_rsp_late", {31'd0, rsp_valid}, 32'd0);
    do_req("lw_30", 0, 32'h30, 32'h0, 3'b010, 32'h00000000, 0);

    begin
      int n = 0;
      while (expq.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("drain", expq.size(), 32'd0);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
